// File: rtl/wb_ram_slave_pkg.sv
// Shared Wishbone bus widths plus the registered request record and
// address-decode helper used by the RAM responder.
package wb_ram_slave_pkg;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_SEL_WIDTH  = 4;

    typedef struct packed {
        logic                     we;
        logic                     bad;
        logic [WB_SEL_WIDTH-1:0]  sel;
        logic [WB_DATA_WIDTH-1:0] dat;
    } wb_req_t;

    // The offset is relative to an aligned base, so its low bits mirror the
    // address alignment; addresses below the base wrap to huge offsets.
    function automatic logic addr_bad(input logic [WB_ADDR_WIDTH-1:0] offset,
                                      input int unsigned size_words);
        return (offset[1:0] != 2'b00) ||
               ({2'b00, offset[WB_ADDR_WIDTH-1:2]} >= size_words);
    endfunction

endpackage

// File: rtl/wb_ram_slave_if.sv
// Wishbone B4 classic-cycle signal bundle between a master and the RAM slave.
interface wb_ram_slave_if;
    import wb_ram_slave_pkg::*;

    logic                     wb_cyc_in;
    logic                     wb_stb_in;
    logic                     wb_we_in;
    logic [WB_SEL_WIDTH-1:0]  wb_sel_in;
    logic [WB_ADDR_WIDTH-1:0] wb_adr_in;
    logic [WB_DATA_WIDTH-1:0] wb_dat_in;
    logic [WB_DATA_WIDTH-1:0] wb_dat_out;
    logic                     wb_ack_out;
    logic                     wb_err_out;

    modport master (
        output wb_cyc_in, wb_stb_in, wb_we_in, wb_sel_in, wb_adr_in, wb_dat_in,
        input  wb_dat_out, wb_ack_out, wb_err_out
    );

    modport slave (
        input  wb_cyc_in, wb_stb_in, wb_we_in, wb_sel_in, wb_adr_in, wb_dat_in,
        output wb_dat_out, wb_ack_out, wb_err_out
    );

endinterface

// File: rtl/wb_ram_array.sv
// Word-organised single-port RAM with byte write enables and a registered
// read port, kept separate so the memory infers cleanly as block RAM.
module wb_ram_array
    import wb_ram_slave_pkg::*;
#(
    parameter int    SIZE_WORDS = 4096,
    parameter string INIT_FILE  = "",
    parameter int    AW         = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1
) (
    input  logic                     clk_in,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [WB_SEL_WIDTH-1:0]  be_i,
    input  logic [AW-1:0]            idx_i,
    input  logic [WB_DATA_WIDTH-1:0] wdata_i,
    output logic [WB_DATA_WIDTH-1:0] rdata_o
);

    logic [WB_DATA_WIDTH-1:0] mem_q [SIZE_WORDS];
    logic [WB_DATA_WIDTH-1:0] rdata_q;

    // No reset: contents survive a bus reset.
    always_ff @(posedge clk_in) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < WB_SEL_WIDTH; b++) begin
                    if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic responder: decodes, optionally stalls WAIT_STATES
// cycles, then answers with a single-cycle ack (RAM access) or err.
module wb_ram_slave
    import wb_ram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          SIZE_WORDS  = 4096,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic            clk_in,
    input  logic            reset_in,
    wb_ram_slave_if.slave   wb
);

    localparam int         AW      = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
    localparam bit         NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_M1   = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        WAIT = 3'b010,
        RESP = 3'b100
    } state_e;

    state_e                   state_q;
    logic [3:0]               cnt_q;
    logic                     ack_q, err_q;
    wb_req_t                  req_q;
    logic [AW-1:0]            idx_q;

    logic [WB_ADDR_WIDTH-1:0] offset;
    wb_req_t                  live_d, cur;
    logic [AW-1:0]            live_idx, cur_idx;
    logic                     accept, wait_done, enter_resp;
    logic [WB_DATA_WIDTH-1:0] rdata;

    assign offset   = wb.wb_adr_in - BASE_ADDR;
    assign live_idx = offset[AW+1:2];

    always_comb begin
        live_d     = '0;
        live_d.we  = wb.wb_we_in;
        live_d.bad = addr_bad(offset, SIZE_WORDS);
        live_d.sel = wb.wb_sel_in;
        live_d.dat = wb.wb_dat_in;
    end

    assign accept     = (state_q == IDLE) && wb.wb_cyc_in && wb.wb_stb_in;
    assign wait_done  = (state_q == WAIT) && (cnt_q == 4'd0) && wb.wb_cyc_in;
    assign enter_resp = (accept && NO_WAIT) || wait_done;

    // With no wait states the RAM is accessed on the accept edge itself, so
    // it must see the live request rather than the registered copy.
    assign cur     = (state_q == IDLE) ? live_d   : req_q;
    assign cur_idx = (state_q == IDLE) ? live_idx : idx_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= '0;
            idx_q   <= '0;
        end else begin
            ack_q <= enter_resp && !cur.bad;
            err_q <= enter_resp &&  cur.bad;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q   <= live_d;
                        idx_q   <= live_idx;
                        cnt_q   <= WS_M1;
                        state_q <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!wb.wb_cyc_in)     state_q <= IDLE;
                    else if (cnt_q == 4'd0) state_q <= RESP;
                    else                    cnt_q   <= cnt_q - 4'd1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    wb_ram_array #(
        .SIZE_WORDS (SIZE_WORDS),
        .INIT_FILE  (INIT_FILE),
        .AW         (AW)
    ) u_ram (
        .clk_in  (clk_in),
        .en_i    (enter_resp && !cur.bad),
        .we_i    (cur.we),
        .be_i    (cur.sel),
        .idx_i   (cur_idx),
        .wdata_i (cur.dat),
        .rdata_o (rdata)
    );

    assign wb.wb_ack_out = ack_q;
    assign wb.wb_err_out = err_q;
    assign wb.wb_dat_out = ack_q ? rdata : '0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: three instances (0, 3 and 4 wait states)
// with a scoreboard of expected responses.
module tb_wb_ram_slave;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          SIZE = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [3:0]  sel  [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    wire         ack  [3];
    wire         err  [3];
    wire  [31:0] rdat [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          err;
        bit          w;
        logic [31:0] dat;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    wb_ram_slave_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].wb_cyc_in = cyc[g];
        assign bus[g].wb_stb_in = stb[g];
        assign bus[g].wb_we_in  = we[g];
        assign bus[g].wb_sel_in = sel[g];
        assign bus[g].wb_adr_in = adr[g];
        assign bus[g].wb_dat_in = wdat[g];
        assign ack[g]  = bus[g].wb_ack_out;
        assign err[g]  = bus[g].wb_err_out;
        assign rdat[g] = bus[g].wb_dat_out;

        wb_ram_slave #(
            .BASE_ADDR   (BASE),
            .SIZE_WORDS  (SIZE),
            .WAIT_STATES ((g == 0) ? 0 : g + 2),
            .INIT_FILE   ("")
        ) dut (
            .clk_in   (clk),
            .reset_in (rst_n),
            .wb       (bus[g])
        );
    end

    function automatic int ws(int d);
        return (d == 0) ? 0 : d + 2;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(int d, bit w, logic [31:0] a, logic [31:0] dt,
                       logic [3:0] s, bit exp_err, logic [31:0] exp_d, string tag);
        exp_t e;
        int   n;
        bit   got;
        e.err = exp_err; e.w = w; e.dat = exp_d; e.lat = 1 + ws(d);
        sbq.push_back(e);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
        sel[d] = s; adr[d] = a; wdat[d] = dt;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[d] || err[d]) got = 1'b1;
        end
        e = sbq.pop_front();
        chk({tag, " responded"}, 32'(got), 32'd1);
        chk({tag, " latency"}, n, e.lat);
        chk({tag, " ack"}, 32'(ack[d]), 32'(!e.err));
        chk({tag, " err"}, 32'(err[d]), 32'(e.err));
        if (!e.w && !e.err) chk({tag, " rdata"}, rdat[d], e.dat);
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(posedge clk); #1;
        chk({tag, " single cycle"}, {30'd0, ack[d], err[d]}, 32'd0);
    endtask

    initial begin
        bit seen;
        for (int d = 0; d < 3; d++) begin
            cyc[d] = 0; stb[d] = 0; we[d] = 0; sel[d] = 0; adr[d] = 0; wdat[d] = 0;
        end
        #12;
        for (int d = 0; d < 3; d++)
            chk("reset outputs", {ack[d], err[d], rdat[d]}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write/read, zero wait states
        req(0, 1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, "wr0");
        req(0, 0, BASE + 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF, "rd0");

        // Byte lanes; read ignores sel
        req(0, 1, BASE + 32'h20, 32'h11223344, 4'hF, 0, 32'h0, "preset");
        req(0, 1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 0, 32'h0, "lanes wr");
        req(0, 0, BASE + 32'h20, 32'h0, 4'hF, 0, 32'h11BB33DD, "lanes rd");
        req(0, 0, BASE + 32'h20, 32'h0, 4'h1, 0, 32'h11BB33DD, "lanes rd sel1");

        // Three wait states
        req(1, 1, BASE + 32'h08, 32'hCAFEF00D, 4'hF, 0, 32'h0, "ws3 wr");
        req(1, 0, BASE + 32'h08, 32'h0, 4'hF, 0, 32'hCAFEF00D, "ws3 rd");

        // Error responses leave RAM untouched
        req(0, 1, BASE,          32'h0BADC0DE, 4'hF, 0, 32'h0, "preset w0");
        req(0, 1, BASE + 32'hFC, 32'h600DF00D, 4'hF, 0, 32'h0, "preset w63");
        req(0, 1, BASE + 32'h2,  32'hFFFFFFFF, 4'hF, 1, 32'h0, "err misalign");
        req(0, 1, BASE + 32'(4*SIZE), 32'hFFFFFFFF, 4'hF, 1, 32'h0, "err top");
        req(0, 1, BASE - 32'h4,  32'hFFFFFFFF, 4'hF, 1, 32'h0, "err below");
        req(0, 0, BASE + 32'h13, 32'h0, 4'hF, 1, 32'h0, "err rd misalign");
        req(0, 0, BASE,          32'h0, 4'hF, 0, 32'h0BADC0DE, "after err w0");
        req(0, 0, BASE + 32'hFC, 32'h0, 4'hF, 0, 32'h600DF00D, "after err w63");

        // Abort during wait states
        req(2, 1, BASE + 32'h30, 32'h12345678, 4'hF, 0, 32'h0, "ws4 wr");
        cyc[2] = 1; stb[2] = 1; we[2] = 1; sel[2] = 4'hF;
        adr[2] = BASE + 32'h30; wdat[2] = 32'h87654321;
        repeat (3) begin @(posedge clk); #1; end
        cyc[2] = 0; stb[2] = 0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack[2] || err[2]) seen = 1'b1;
        end
        chk("abort no response", 32'(seen), 32'd0);
        req(2, 0, BASE + 32'h30, 32'h0, 4'hF, 0, 32'h12345678, "abort rd");

        // Reset in the middle of a waited write
        cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'hF;
        adr[1] = BASE + 32'h08; wdat[1] = 32'h0;
        repeat (2) begin @(posedge clk); #1; end
        #2; rst_n = 1'b0; #1;
        chk("rst wait outputs", {ack[1], err[1], rdat[1]}, 32'd0);
        cyc[1] = 0; stb[1] = 0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); #1;
        req(1, 0, BASE + 32'h08, 32'h0, 4'hF, 0, 32'hCAFEF00D, "after rst rd");

        // Reset during the response cycle clears outputs at once
        cyc[0] = 1; stb[0] = 1; we[0] = 0; sel[0] = 4'hF; adr[0] = BASE + 32'h10;
        @(posedge clk); #1;
        chk("resp ack before rst", 32'(ack[0]), 32'd1);
        rst_n = 1'b0; #1;
        chk("rst resp ack", 32'(ack[0]), 32'd0);
        chk("rst resp dat", rdat[0], 32'd0);
        cyc[0] = 0; stb[0] = 0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        req(0, 0, BASE + 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF, "after rst2 rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
